mem_ctrl: RTL
=============

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have ports: clk_in  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_in  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have: rdy_in  in  1  global ready; low freezes all state.
REQ-004 SHALL have ICache-side ports: need_mem in 1 fetch request; mem_addr in 32 fetch byte address; mem_ins out 32 fetched word; mem_ins_ready out 1 one-cycle completion pulse.
REQ-005 SHALL have LSB-side ports: lsb_valid in 1 request; lsb_wr in 1 1=store; lsb_addr in 32; lsb_len in 2 (0 byte, 1 half, 2 word, 3 reserved→word); lsb_wdata in 32; lsb_rdata out 32; lsb_ready out 1 one-cycle completion pulse.
REQ-006 SHALL have RAM-side ports: ram_din in 8 read byte; ram_dout out 8 write byte; ram_a out 32 byte address; ram_wr out 1 write strobe, 1=write.
REQ-007 SHALL have io_buffer_full in 1; when high, stores to 0x30000 or 0x30004 are held.

Function
REQ-008 SHALL treat RAM as synchronous: ram_din in cycle n holds the byte addressed by ram_a in cycle n-1; a write occurs in any cycle with ram_wr=1.
REQ-009 SHALL implement states IDLE, FETCH, LOAD, STORE, DONE.
REQ-010 SHALL, in IDLE, accept lsb_valid before need_mem when both high at the same edge (data priority).
REQ-011 SHALL latch address, length, data and write flag at acceptance; later request-input changes SHALL NOT affect the transaction.
REQ-012 SHALL, for a fetch accepted at edge E0, drive ram_a = addr+k, ram_wr=0 in cycle after E(k), k=0..3.
REQ-013 SHALL capture byte k at edge E(k+2) into bits [8k+7:8k] (little-endian).
REQ-014 SHALL, at E5, load mem_ins with the full word and assert mem_ins_ready for exactly the cycle E5-E6; mem_ins SHALL hold its value until the next fetch completes.
REQ-015 SHALL handle loads like fetches with N=1/2/4 bytes: ready pulse at edge E(N+1); lsb_rdata bits above 8N zero-filled.
REQ-016 SHALL, for a store accepted at E0, drive ram_a=addr+k, ram_dout=wdata[8k+7:8k], ram_wr=1 in cycle after E(k), k=0..N-1, then assert lsb_ready in cycle after E(N) with ram_wr=0.
REQ-017 SHALL, for a store to 0x30000/0x30004 while io_buffer_full=1, remain in STORE with ram_wr=0 and issue no byte until io_buffer_full=0 at a rising edge.
REQ-018 SHALL enter DONE for the single cycle following each ready pulse; requests SHALL NOT be accepted at the edge ending a ready pulse, so a requester dropping its request at that same edge does not cause a duplicate access.
REQ-019 SHALL keep ram_wr=0 in IDLE, FETCH, LOAD and DONE.
REQ-020 SHALL compute addr+k in 32 bits with wrap from 0xFFFFFFFF to 0.
REQ-021 SHALL, while rdy_in=0, hold state, counters, ram_a, ram_dout; drive ram_wr=0; not pulse any ready output; resume exactly where frozen; a byte read during the frozen cycles SHALL be re-issued.
REQ-022 SHALL never assert mem_ins_ready and lsb_ready in the same cycle.

Reset
REQ-023 SHALL, on rst_in low, immediately (asynchronously) enter IDLE with mem_ins=0, mem_ins_ready=0, lsb_rdata=0, lsb_ready=0, ram_a=0, ram_dout=0, ram_wr=0.
REQ-024 SHALL abandon any in-flight transaction on reset; no ready pulse for it after release.
REQ-025 SHALL accept requests at the first rising edge after rst_in returns high with rdy_in=1.

Verification
REQ-026 Fetch: RAM[0x100..0x103]=13,05,00,00, need_mem=1 addr 0x100 → mem_ins=0x00000513, mem_ins_ready single pulse 5 cycles after acceptance, no second fetch.
REQ-027 Collision: need_mem and lsb_valid (load byte 0x200, RAM=0xAB) same edge → lsb_rdata=0x000000AB first, then fetch completes, pulses never overlap.
REQ-028 Store half 0x1234 to 0x300 → ram_wr for 2 cycles writing 0x34@0x300, 0x12@0x301, then lsb_ready pulse.
REQ-029 Store byte to 0x30000 with io_buffer_full=1 for 10 cycles → no ram_wr until release, then one write, lsb_ready.
REQ-030 rdy_in low 3 cycles mid-fetch → correct word, ready delayed by exactly 3 cycles; rst_in low mid-load → outputs zero asynchronously, no ready after release.

Source files
------------

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial arbiter between instruction fetch and load/store over a synchronous 8-bit RAM
// One transaction at a time; the data side wins ties, and a DONE cycle guards against duplicate accepts.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        need_mem,
  input  logic [31:0] mem_addr,
  output logic [31:0] mem_ins,
  output logic        mem_ins_ready,
  input  logic        lsb_valid,
  input  logic        lsb_wr,
  input  logic [31:0] lsb_addr,
  input  logic [1:0]  lsb_len,
  input  logic [31:0] lsb_wdata,
  output logic [31:0] lsb_rdata,
  output logic        lsb_ready,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr,
  input  logic        io_buffer_full
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_STORE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]  r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_nbytes;
  logic [2:0]  r_cnt;
  logic [31:0] r_buf;
  logic [7:0]  r_held;
  logic        r_frz;
  logic [31:0] r_ins;
  logic        r_ins_rdy;
  logic [31:0] r_rdata;
  logic        r_lsb_rdy;
  logic [31:0] r_a;
  logic [7:0]  r_dout;
  logic        r_wr;

  logic [7:0]  w_din;
  logic [2:0]  w_acc_nbytes;
  logic        w_acc_io;
  logic        w_io_hold;
  logic [31:0] w_merged;
  logic [7:0]  w_wbyte;
  logic        w_busy_ready;

  // The byte returned during the first frozen cycle is the one still owed; later frozen cycles return the held address.
  assign w_din        = r_frz ? r_held : ram_din;
  assign w_acc_io     = (lsb_addr == 32'h0003_0000) || (lsb_addr == 32'h0003_0004);
  assign w_io_hold    = ((r_addr == 32'h0003_0000) || (r_addr == 32'h0003_0004)) && io_buffer_full;
  assign w_merged     = r_buf | ({24'd0, w_din} << {r_cnt - 3'd1, 3'b000});
  assign w_busy_ready = r_ins_rdy | r_lsb_rdy;

  always_comb begin
    w_acc_nbytes = 3'd4;
    case (lsb_len)
      2'd0:    w_acc_nbytes = 3'd1;
      2'd1:    w_acc_nbytes = 3'd2;
      default: w_acc_nbytes = 3'd4;
    endcase
  end

  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt[1:0])
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      2'd3:    w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state   <= S_IDLE;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_nbytes  <= 3'd0;
      r_cnt     <= 3'd0;
      r_buf     <= 32'd0;
      r_held    <= 8'd0;
      r_frz     <= 1'b0;
      r_ins     <= 32'd0;
      r_ins_rdy <= 1'b0;
      r_rdata   <= 32'd0;
      r_lsb_rdy <= 1'b0;
      r_a       <= 32'd0;
      r_dout    <= 8'd0;
      r_wr      <= 1'b0;
    end else if (!rdy_in) begin
      if (!r_frz) begin
        r_held <= ram_din;
      end
      r_frz <= 1'b1;
    end else begin
      r_frz <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (lsb_valid) begin
            r_addr   <= lsb_addr;
            r_wdata  <= lsb_wdata;
            r_nbytes <= w_acc_nbytes;
            r_buf    <= 32'd0;
            if (lsb_wr) begin
              r_state <= S_STORE;
              if (w_acc_io && io_buffer_full) begin
                r_cnt <= 3'd0;
                r_wr  <= 1'b0;
              end else begin
                r_a    <= lsb_addr;
                r_dout <= lsb_wdata[7:0];
                r_wr   <= 1'b1;
                r_cnt  <= 3'd1;
              end
            end else begin
              r_state <= S_LOAD;
              r_a     <= lsb_addr;
              r_cnt   <= 3'd0;
            end
          end else if (need_mem) begin
            r_state  <= S_FETCH;
            r_addr   <= mem_addr;
            r_nbytes <= 3'd4;
            r_buf    <= 32'd0;
            r_a      <= mem_addr;
            r_cnt    <= 3'd0;
          end
        end
        S_FETCH, S_LOAD: begin
          if (w_busy_ready) begin
            r_ins_rdy <= 1'b0;
            r_lsb_rdy <= 1'b0;
            r_state   <= S_DONE;
          end else begin
            // r_cnt is the index of the address on the bus; its data lands one edge later.
            if (r_cnt + 3'd1 < r_nbytes) begin
              r_a <= r_addr + {29'd0, r_cnt} + 32'd1;
            end
            if (r_cnt != 3'd0) begin
              r_buf <= w_merged;
            end
            if (r_cnt == r_nbytes) begin
              if (r_state == S_FETCH) begin
                r_ins     <= w_merged;
                r_ins_rdy <= 1'b1;
              end else begin
                r_rdata   <= w_merged;
                r_lsb_rdy <= 1'b1;
              end
            end
            r_cnt <= r_cnt + 3'd1;
          end
        end
        S_STORE: begin
          if (r_lsb_rdy) begin
            r_lsb_rdy <= 1'b0;
            r_state   <= S_DONE;
          end else if (r_cnt == r_nbytes) begin
            r_wr      <= 1'b0;
            r_lsb_rdy <= 1'b1;
          end else if (w_io_hold) begin
            r_wr <= 1'b0;
          end else begin
            r_a    <= r_addr + {29'd0, r_cnt};
            r_dout <= w_wbyte;
            r_wr   <= 1'b1;
            r_cnt  <= r_cnt + 3'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mem_ins       = r_ins;
  assign mem_ins_ready = r_ins_rdy & rdy_in;
  assign lsb_rdata     = r_rdata;
  assign lsb_ready     = r_lsb_rdy & rdy_in;
  assign ram_a         = r_a;
  assign ram_dout      = r_dout;
  assign ram_wr        = r_wr & rdy_in;

endmodule
